acc_bank: RTL
=============

# acc_bank

Parametrised accumulator bank that replaces the single 8-bit accumulator register between the ALU output and the datapath. It holds `NUM_ACC` accumulators, each with its own Z/N/C/V flag register. It executes load, clear, shift and context push/pop operations selected by a 3-bit opcode. A LIFO context stack of depth `STACK_DEPTH` saves and restores accumulator and flags for subroutine and interrupt entry.

## Interface
- `WIDTH`, 8: accumulator width in bits, ≥ 2.
- `NUM_ACC`, 2: number of accumulators, ≥ 2, power of two.
- `STACK_DEPTH`, 4: context stack entries, ≥ 1.
- `clk` input 1: system clock; all state updates on the falling edge.
- `reset` input 1: reset, asynchronous, active-high.
- `op` input 3: operation code, sampled at the falling edge.
- `sel` input $clog2(NUM_ACC): accumulator targeted by `op` and shown on the outputs.
- `acc_in` input WIDTH: ALU result.
- `flags_in` input 4: ALU flags {Z,N,C,V}.
- `acc_out` output WIDTH: contents of accumulator `sel`, combinational read.
- `flags_out` output 4: flags of accumulator `sel`, as {Z,N,C,V}, combinational read.
- `stack_count` output $clog2(STACK_DEPTH+1): occupied stack entries.
- `stack_full` output 1: `stack_count == STACK_DEPTH`.
- `stack_empty` output 1: `stack_count == 0`.
- `stack_err` output 1: sticky; set by push-when-full or pop-when-empty.

## Operation
- Opcodes:
  - 000 NOP: no change.
  - 001 LOAD: `acc[sel] <= acc_in`, `flags[sel] <= flags_in`.
  - 010 CLEAR: `acc[sel] <= 0`, `flags[sel] <= 4'b1000`.
  - 011 SHL: logical left shift of `acc[sel]`, zero fill.
  - 100 SHR: logical right shift of `acc[sel]`, zero fill.
  - 101 PUSH: `{acc[sel], flags[sel]}` written to `stack[count]`, then count+1.
  - 110 POP: count-1, then `{acc[sel], flags[sel]}` loaded from the new top entry.
  - 111 CLEAR_ALL: every accumulator cleared, every flag register set to 4'b1000, count=0, `stack_err`=0.
- Shift flags:
  - Z = (result == 0); N = result[WIDTH-1].
  - C = bit shifted out: old MSB for SHL, old LSB for SHR.
  - V = old[WIDTH-1] ^ old[WIDTH-2] for SHL; V = 0 for SHR.
- PUSH while full: stack and accumulator unchanged, `stack_err` set.
- POP while empty: accumulator, flags and stack unchanged, `stack_err` set.
- `stack_err` is cleared only by `reset` or CLEAR_ALL.
- Accumulators not addressed by `sel` are never modified, except by CLEAR_ALL.
- Stack entries above `stack_count` are don't-care and are not cleared.
- PUSH from one accumulator followed by POP into another is legal. This is the register-move mechanism.

## Timing
- Reset values: all accumulators 0; all flags 4'b1000; `stack_count` 0; `stack_empty` 1; `stack_full` 0; `stack_err` 0.
- Reset takes effect immediately and asynchronously, including mid-sequence. The outputs read reset values with no clock edge.
- Latency: one falling edge. A result written at edge n is visible on `acc_out`/`flags_out` after edge n, for the same `sel`.
- Changing `sel` alone changes the outputs combinationally, with no state change.
- The ALU is combinational on `acc_out`. A feedback loop of LOAD, ALU, LOAD therefore runs one operation per clock.
- One operation per edge. No pipelining and no back-pressure; the block is always ready.
- PUSH and POP in consecutive cycles are legal. `stack_count`, `stack_full` and `stack_empty` update on the same edge as the operation.

## Structure
- Shared package `acc_pkg`:
  - opcode localparams `ACC_NOP` .. `ACC_CLEAR_ALL`;
  - flag bit indices `FLG_Z=3`, `FLG_N=2`, `FLG_C=1`, `FLG_V=0`;
  - `FLAGS_RESET = 4'b1000`.
- Sub-module `acc_ctx_stack`, parametrised by `DATA_W = WIDTH+4` and `DEPTH`.
  - Inputs: push, pop, din.
  - Outputs: dout (top entry), count, full, empty, err.
  - It is a falling-edge LIFO with async reset of the pointer and err only.
- `acc_bank` holds the accumulator/flag arrays, the opcode decode and the shift/flag logic.

## Test plan
- Reset: assert `reset` mid-cycle after loading acc0=0x5A. Required: `acc_out`=0x00, `flags_out`=4'b1000, `stack_empty`=1, `stack_err`=0, all immediately.
- LOAD/select: LOAD acc0=0x3C with flags 0000, then LOAD acc1=0x81 with flags 0100. Required: `sel`=0 reads 0x3C/0000; `sel`=1 reads 0x81/0100; acc0 unchanged by the acc1 write.
- Shifts:
  - SHL on 0xC0 → 0x80, flags Z0 N1 C1 V0.
  - SHL on 0x40 → 0x80, V1.
  - SHR on 0x01 → 0x00, flags Z1 N0 C1 V0.
- Stack fill/overflow (`STACK_DEPTH`=4):
  - PUSH values 0x11, 0x22, 0x33, 0x44. Required: `stack_full`=1, `stack_count`=4.
  - Fifth PUSH. Required: `stack_err`=1, count stays 4.
  - Four POPs into acc1. Required: 0x44, 0x33, 0x22, 0x11 in order, then `stack_empty`=1.
- Underflow and recovery:
  - POP when empty with acc0=0x77. Required: acc0 stays 0x77, `stack_err`=1.
  - CLEAR_ALL. Required: `stack_err`=0, every accumulator 0x00, every flag register 1000.
- Move: acc0=0xA5, PUSH `sel`=0, POP `sel`=1. Required: acc1=0xA5 with acc0's flags, acc0 still 0xA5.

Source files
------------

// File: rtl/acc_pkg.sv
// Shared opcode, flag-index and reset-value definitions for the accumulator bank.
package acc_pkg;

  localparam logic [2:0] ACC_NOP       = 3'b000;
  localparam logic [2:0] ACC_LOAD      = 3'b001;
  localparam logic [2:0] ACC_CLEAR     = 3'b010;
  localparam logic [2:0] ACC_SHL       = 3'b011;
  localparam logic [2:0] ACC_SHR       = 3'b100;
  localparam logic [2:0] ACC_PUSH      = 3'b101;
  localparam logic [2:0] ACC_POP       = 3'b110;
  localparam logic [2:0] ACC_CLEAR_ALL = 3'b111;

  // Flags are packed as {Z,N,C,V}
  localparam int FLG_Z = 3;
  localparam int FLG_N = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

  localparam logic [3:0] FLAGS_RESET = 4'b1000;

endpackage

// File: rtl/acc_bank_if.sv
// Operation/readback bundle between the datapath (master) and the accumulator bank (slave).
interface acc_bank_if #(
  parameter int WIDTH       = 8,
  parameter int NUM_ACC     = 2,
  parameter int STACK_DEPTH = 4
);
  localparam int SW = $clog2(NUM_ACC);
  localparam int CW = $clog2(STACK_DEPTH + 1);

  logic [2:0]       op;
  logic [SW-1:0]    sel;
  logic [WIDTH-1:0] acc_in;
  logic [3:0]       flags_in;
  logic [WIDTH-1:0] acc_out;
  logic [3:0]       flags_out;
  logic [CW-1:0]    stack_count;
  logic             stack_full;
  logic             stack_empty;
  logic             stack_err;

  modport master (
    output op, sel, acc_in, flags_in,
    input  acc_out, flags_out, stack_count, stack_full, stack_empty, stack_err
  );

  modport slave (
    input  op, sel, acc_in, flags_in,
    output acc_out, flags_out, stack_count, stack_full, stack_empty, stack_err
  );

endinterface

// File: rtl/acc_ctx_stack.sv
// Falling-edge LIFO for saved accumulator contexts; only the pointer and error flag are reset.
module acc_ctx_stack #(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clr,
  input  logic [DATA_W-1:0]          din,
  output logic [DATA_W-1:0]          dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [CW-1:0]     r_count;
  logic              r_err;
  logic [AW-1:0]     w_wrAddr;
  logic [AW-1:0]     w_topAddr;
  logic              w_doPush;
  logic              w_doPop;

  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == '0);
  assign w_doPush  = push && !full;
  assign w_doPop   = pop && !empty;
  assign w_wrAddr  = AW'(r_count);
  assign w_topAddr = AW'(r_count - CW'(1));
  assign dout      = r_mem[w_topAddr];
  assign count     = r_count;
  assign err       = r_err;

  always_ff @(negedge clk) begin
    if (w_doPush) r_mem[w_wrAddr] <= din;
  end

  // Rejected push/pop leave the pointer alone but latch the error until cleared
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_err   <= 1'b0;
    end else if (clr) begin
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_doPush)     r_count <= r_count + CW'(1);
      else if (w_doPop) r_count <= r_count - CW'(1);
      if ((push && full) || (pop && empty)) r_err <= 1'b1;
    end
  end

endmodule

// File: rtl/acc_bank.sv
// Bank of accumulators with per-accumulator Z/N/C/V flags, shift unit and context stack.
module acc_bank
  import acc_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int NUM_ACC     = 2,
  parameter int STACK_DEPTH = 4
) (
  input logic       clk,
  input logic       reset,
  acc_bank_if.slave bus
);

  localparam int DW = WIDTH + 4;

  logic [WIDTH-1:0] r_acc   [NUM_ACC];
  logic [3:0]       r_flags [NUM_ACC];

  logic [WIDTH-1:0] w_cur;
  logic [WIDTH-1:0] w_shl;
  logic [WIDTH-1:0] w_shr;
  logic [3:0]       w_shlFlags;
  logic [3:0]       w_shrFlags;
  logic [DW-1:0]    w_popData;
  logic             w_stackEmpty;

  assign w_cur = r_acc[bus.sel];
  assign w_shl = {w_cur[WIDTH-2:0], 1'b0};
  assign w_shr = {1'b0, w_cur[WIDTH-1:1]};

  // Carry is the bit shifted out; V on SHL flags a sign change
  always_comb begin
    w_shlFlags        = '0;
    w_shlFlags[FLG_Z] = (w_shl == '0);
    w_shlFlags[FLG_N] = w_shl[WIDTH-1];
    w_shlFlags[FLG_C] = w_cur[WIDTH-1];
    w_shlFlags[FLG_V] = w_cur[WIDTH-1] ^ w_cur[WIDTH-2];
    w_shrFlags        = '0;
    w_shrFlags[FLG_Z] = (w_shr == '0);
    w_shrFlags[FLG_N] = w_shr[WIDTH-1];
    w_shrFlags[FLG_C] = w_cur[0];
  end

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_ACC; i++) begin
        r_acc[i]   <= '0;
        r_flags[i] <= FLAGS_RESET;
      end
    end else begin
      case (bus.op)
        ACC_LOAD: begin
          r_acc[bus.sel]   <= bus.acc_in;
          r_flags[bus.sel] <= bus.flags_in;
        end
        ACC_CLEAR: begin
          r_acc[bus.sel]   <= '0;
          r_flags[bus.sel] <= FLAGS_RESET;
        end
        ACC_SHL: begin
          r_acc[bus.sel]   <= w_shl;
          r_flags[bus.sel] <= w_shlFlags;
        end
        ACC_SHR: begin
          r_acc[bus.sel]   <= w_shr;
          r_flags[bus.sel] <= w_shrFlags;
        end
        ACC_POP: begin
          if (!w_stackEmpty) begin
            r_acc[bus.sel]   <= w_popData[DW-1:4];
            r_flags[bus.sel] <= w_popData[3:0];
          end
        end
        ACC_CLEAR_ALL: begin
          for (int i = 0; i < NUM_ACC; i++) begin
            r_acc[i]   <= '0;
            r_flags[i] <= FLAGS_RESET;
          end
        end
        default: ;
      endcase
    end
  end

  acc_ctx_stack #(
    .DATA_W (DW),
    .DEPTH  (STACK_DEPTH)
  ) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (bus.op == ACC_PUSH),
    .pop   (bus.op == ACC_POP),
    .clr   (bus.op == ACC_CLEAR_ALL),
    .din   ({w_cur, r_flags[bus.sel]}),
    .dout  (w_popData),
    .count (bus.stack_count),
    .full  (bus.stack_full),
    .empty (w_stackEmpty),
    .err   (bus.stack_err)
  );

  assign bus.stack_empty = w_stackEmpty;
  assign bus.acc_out     = w_cur;
  assign bus.flags_out   = r_flags[bus.sel];

endmodule
